// File: rtl/matrix_exec_unit_if.sv
// Op/response handshake between the decode/hazard side and matrix_exec_unit.
interface matrix_exec_unit_if #(
    parameter int unsigned DATA_W = 32
);
    logic              op_valid;
    logic              op_ready;
    logic [3:0]        op_code;
    logic [DATA_W-1:0] op_a;
    logic [DATA_W-1:0] op_b;
    logic              flush;
    logic              busy;
    logic              result_valid;
    logic [DATA_W-1:0] result_data;
    logic              op_err;

    modport master (
        output op_valid, op_code, op_a, op_b, flush,
        input  op_ready, busy, result_valid, result_data, op_err
    );

    modport slave (
        input  op_valid, op_code, op_a, op_b, flush,
        output op_ready, busy, result_valid, result_data, op_err
    );
endinterface

// File: rtl/matrix_exec_unit.sv
// Execute-stage matrix unit: loads A/B, runs C=A*B (and optional 2x2 inverse), returns one scalar per op.
// Define MATRIX_INV_EN to build the MATINV datapath; otherwise MATINV reports op_err.
module matrix_exec_unit #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned N      = 2
) (
    input logic               clk,
    input logic               rst_n,
    matrix_exec_unit_if.slave bus
);
    localparam int unsigned NN    = N * N;
    localparam int unsigned IDX_W = $clog2(NN);
    localparam int unsigned CNT_W = $clog2(N);

    localparam logic [3:0] OP_LMA = 4'b1000;
    localparam logic [3:0] OP_LMB = 4'b1001;
    localparam logic [3:0] OP_MUL = 4'b1011;
`ifdef MATRIX_INV_EN
    localparam logic [3:0] OP_INV = 4'b1010;
    localparam logic [IDX_W-1:0] IDX_A = IDX_W'(0);
    localparam logic [IDX_W-1:0] IDX_B = IDX_W'(1);
    localparam logic [IDX_W-1:0] IDX_C = IDX_W'(2);
    localparam logic [IDX_W-1:0] IDX_D = IDX_W'(3);
`endif

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_RESP = 2'd2
`ifdef MATRIX_INV_EN
        , ST_INV = 2'd3
`endif
    } state_t;

    state_t            state;
    logic [DATA_W-1:0] mat_a [NN];
    logic [DATA_W-1:0] mat_b [NN];
    logic [DATA_W-1:0] mat_c [NN];
    logic [CNT_W-1:0]  i_cnt;
    logic [CNT_W-1:0]  j_cnt;
    logic [CNT_W-1:0]  k_cnt;
    logic [IDX_W-1:0]  idx_q;
    logic [DATA_W-1:0] acc;
    logic              result_valid_q;
    logic              op_err_q;
    logic [DATA_W-1:0] result_data_q;
`ifdef MATRIX_INV_EN
    logic [DATA_W-1:0] inv_p;
    logic [DATA_W-1:0] inv_q;
    logic              inv_phase;
`endif

    // MAC datapath: k is the reduction index, C[i][j] is written when k wraps
    logic [IDX_W-1:0]  idx_in_c;
    logic [IDX_W-1:0]  a_idx_c;
    logic [IDX_W-1:0]  b_idx_c;
    logic [IDX_W-1:0]  c_idx_c;
    logic [DATA_W-1:0] prod_c;
    logic [DATA_W-1:0] mac_c;
    logic              mul_last_c;
    logic              unused_b;

    assign idx_in_c   = bus.op_b[IDX_W-1:0];
    assign a_idx_c    = {i_cnt, k_cnt};
    assign b_idx_c    = {k_cnt, j_cnt};
    assign c_idx_c    = {i_cnt, j_cnt};
    assign prod_c     = mat_a[a_idx_c] * mat_b[b_idx_c];
    assign mac_c      = (k_cnt == '0) ? prod_c : acc + prod_c;
    assign mul_last_c = (i_cnt == CNT_LAST) && (j_cnt == CNT_LAST) && (k_cnt == CNT_LAST);
    assign unused_b   = ^bus.op_b[DATA_W-1:IDX_W];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state          <= ST_IDLE;
            i_cnt          <= '0;
            j_cnt          <= '0;
            k_cnt          <= '0;
            idx_q          <= '0;
            acc            <= '0;
            result_valid_q <= 1'b0;
            op_err_q       <= 1'b0;
            result_data_q  <= '0;
            for (int e = 0; e < NN; e++) begin
                mat_a[e] <= '0;
                mat_b[e] <= '0;
                mat_c[e] <= '0;
            end
`ifdef MATRIX_INV_EN
            inv_p     <= '0;
            inv_q     <= '0;
            inv_phase <= 1'b0;
`endif
        end else begin
            result_valid_q <= 1'b0;
            op_err_q       <= 1'b0;
            if (bus.flush) begin
                state <= ST_IDLE;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (bus.op_valid) begin
                            idx_q <= idx_in_c;
                            i_cnt <= '0;
                            j_cnt <= '0;
                            k_cnt <= '0;
                            case (bus.op_code)
                                OP_LMA: begin
                                    mat_a[idx_in_c] <= bus.op_a;
                                    result_data_q   <= bus.op_a;
                                    result_valid_q  <= 1'b1;
                                    state           <= ST_RESP;
                                end
                                OP_LMB: begin
                                    mat_b[idx_in_c] <= bus.op_a;
                                    result_data_q   <= bus.op_a;
                                    result_valid_q  <= 1'b1;
                                    state           <= ST_RESP;
                                end
                                OP_MUL: begin
                                    state <= ST_MUL;
                                end
`ifdef MATRIX_INV_EN
                                OP_INV: begin
                                    if (N == 2) begin
                                        inv_phase <= 1'b0;
                                        state     <= ST_INV;
                                    end else begin
                                        result_data_q  <= '0;
                                        result_valid_q <= 1'b1;
                                        op_err_q       <= 1'b1;
                                        state          <= ST_RESP;
                                    end
                                end
`endif
                                default: begin
                                    result_data_q  <= '0;
                                    result_valid_q <= 1'b1;
                                    op_err_q       <= 1'b1;
                                    state          <= ST_RESP;
                                end
                            endcase
                        end
                    end
                    ST_MUL: begin
                        acc <= mac_c;
                        if (k_cnt == CNT_LAST) begin
                            mat_c[c_idx_c] <= mac_c;
                        end
                        if (mul_last_c) begin
                            // the requested element may be the one being written this edge
                            result_data_q  <= (idx_q == c_idx_c) ? mac_c : mat_c[idx_q];
                            result_valid_q <= 1'b1;
                            state          <= ST_RESP;
                        end else if (k_cnt == CNT_LAST) begin
                            k_cnt <= '0;
                            if (j_cnt == CNT_LAST) begin
                                j_cnt <= '0;
                                i_cnt <= i_cnt + CNT_W'(1);
                            end else begin
                                j_cnt <= j_cnt + CNT_W'(1);
                            end
                        end else begin
                            k_cnt <= k_cnt + CNT_W'(1);
                        end
                    end
`ifdef MATRIX_INV_EN
                    ST_INV: begin
                        if (!inv_phase) begin
                            inv_p     <= mat_a[IDX_A] * mat_a[IDX_D];
                            inv_q     <= mat_a[IDX_B] * mat_a[IDX_C];
                            inv_phase <= 1'b1;
                        end else begin
                            // adjugate into C; the scalar returned is the determinant
                            mat_c[IDX_A]   <= mat_a[IDX_D];
                            mat_c[IDX_B]   <= -mat_a[IDX_B];
                            mat_c[IDX_C]   <= -mat_a[IDX_C];
                            mat_c[IDX_D]   <= mat_a[IDX_A];
                            result_data_q  <= inv_p - inv_q;
                            result_valid_q <= 1'b1;
                            state          <= ST_RESP;
                        end
                    end
`endif
                    ST_RESP: begin
                        state <= ST_IDLE;
                    end
                    default: begin
                        state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    assign bus.op_ready     = (state == ST_IDLE);
    assign bus.busy         = (state != ST_IDLE);
    assign bus.result_valid = result_valid_q;
    assign bus.result_data  = result_data_q;
    assign bus.op_err       = op_err_q;

endmodule
